beam_thresh_sequencer: RTL and testbench



---
 rtl/beam_thresh_sequencer.sv | 147 ++++++++++++++
 tb/tb_beam_thresh_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_thresh_sequencer.sv
// Per-beam threshold RAM that shifts both lanes into the beamformer cascade and commits them.
// Optional host readback port and per-lane committed flags: define BEAM_THRESH_SEQ_READBACK_EN.
module beam_thresh_sequencer #(
    parameter int                     NBEAMS         = 48,
    parameter int                     THRESH_BITS    = 18,
    parameter logic [THRESH_BITS-1:0] DEFAULT_THRESH = 18'd4000
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      thr_wr_i,
    input  logic                      thr_lane_i,
    input  logic [$clog2(NBEAMS)-1:0] thr_addr_i,
    input  logic [THRESH_BITS-1:0]    thr_dat_i,
    input  logic                      apply_i,
    input  logic [1:0]                apply_mask_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [2*THRESH_BITS-1:0]  thresh_o,
    output logic [1:0]                thresh_wr_o,
    output logic [1:0]                thresh_update_o
`ifdef BEAM_THRESH_SEQ_READBACK_EN
    ,
    input  logic                      rd_lane_i,
    input  logic [$clog2(NBEAMS)-1:0] rd_addr_i,
    output logic [THRESH_BITS-1:0]    rd_dat_o,
    output logic [1:0]                committed_o
`endif
);

    localparam int AW = $clog2(NBEAMS);
    localparam logic [AW-1:0] LAST_BEAM = AW'(NBEAMS - 1);

    typedef enum logic [2:0] {IDLE, PRIME, SHIFT, COMMIT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          cnt_q;
    logic [1:0]             mask_q;
    logic                   pend_q;
    logic [1:0]             pend_mask_q;
    logic                   apply_req;
    logic                   wr_ok;
    logic                   seq_rd;
    logic [AW-1:0]          seq_addr;

    logic [THRESH_BITS-1:0] ram0 [NBEAMS] = '{default: DEFAULT_THRESH};
    logic [THRESH_BITS-1:0] ram1 [NBEAMS] = '{default: DEFAULT_THRESH};

    assign apply_req = apply_i && (apply_mask_i != 2'b00);
    assign wr_ok     = thr_wr_i && (int'(thr_addr_i) < NBEAMS);

    // NOTE: the RAM has no reset; thresholds must survive a trigger-domain reset.
    always_ff @(posedge clk_i) begin
        if (wr_ok && !thr_lane_i) ram0[thr_addr_i] <= thr_dat_i;
        if (wr_ok &&  thr_lane_i) ram1[thr_addr_i] <= thr_dat_i;
    end

    // PRIME fetches the top beam; each SHIFT cycle prefetches the beam below the one on thresh_o.
    assign seq_rd   = (state_q == PRIME) || (state_q == SHIFT && cnt_q != '0);
    assign seq_addr = (state_q == PRIME) ? LAST_BEAM : cnt_q - AW'(1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       thresh_o <= '0;
        else if (seq_rd) thresh_o <= {ram1[seq_addr], ram0[seq_addr]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
        state_d         = state_q;
        busy_o          = 1'b0;
        done_o          = 1'b0;
        thresh_wr_o     = 2'b00;
        thresh_update_o = 2'b00;
        unique case (state_q)
            IDLE:   if (apply_req) state_d = PRIME;
            PRIME: begin
                busy_o  = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                busy_o      = 1'b1;
                thresh_wr_o = mask_q;
                if (cnt_q == '0) state_d = COMMIT;
            end
            COMMIT: begin
                busy_o          = 1'b1;
                thresh_update_o = mask_q;
                state_d         = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = (pend_q || apply_req) ? PRIME : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            mask_q      <= 2'b00;
            pend_q      <= 1'b0;
            pend_mask_q <= 2'b00;
        end else begin
            if (state_q == PRIME)                      cnt_q <= LAST_BEAM;
            else if (state_q == SHIFT && cnt_q != '0)  cnt_q <= cnt_q - AW'(1);

            if (state_q == IDLE) begin
                if (apply_req) mask_q <= apply_mask_i;
            end else if (state_q == DONE) begin
                // Requests that arrived while busy collapse into one back-to-back sequence.
                if (pend_q || apply_req)
                    mask_q <= pend_mask_q | (apply_req ? apply_mask_i : 2'b00);
                pend_q      <= 1'b0;
                pend_mask_q <= 2'b00;
            end else if (apply_req) begin
                pend_q      <= 1'b1;
                pend_mask_q <= pend_mask_q | apply_mask_i;
            end
        end
    end

`ifdef BEAM_THRESH_SEQ_READBACK_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_dat_o    <= '0;
            committed_o <= 2'b00;
        end else begin
            if (int'(rd_addr_i) < NBEAMS)
                rd_dat_o <= rd_lane_i ? ram1[rd_addr_i] : ram0[rd_addr_i];
            else
                rd_dat_o <= '0;
            // A host write makes the RAM differ from what the beamformer holds, so clear wins.
            committed_o[0] <= (thr_wr_i && !thr_lane_i) ? 1'b0
                              : (committed_o[0] | (state_q == COMMIT && mask_q[0]));
            committed_o[1] <= (thr_wr_i &&  thr_lane_i) ? 1'b0
                              : (committed_o[1] | (state_q == COMMIT && mask_q[1]));
        end
    end
`endif

endmodule

// File: tb/tb_beam_thresh_sequencer.sv
// Directed bench for beam_thresh_sequencer: idle vector table plus hand-written sequence checks.
module tb_beam_thresh_sequencer;

    localparam int NB = 48;
    localparam int TW = 18;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            thr_wr_i = 1'b0;
    logic            thr_lane_i = 1'b0;
    logic [5:0]      thr_addr_i = '0;
    logic [TW-1:0]   thr_dat_i = '0;
    logic            apply_i = 1'b0;
    logic [1:0]      apply_mask_i = 2'b00;
    logic            busy_o;
    logic            done_o;
    logic [2*TW-1:0] thresh_o;
    logic [1:0]      thresh_wr_o;
    logic [1:0]      thresh_update_o;

    int checks = 0;
    int errors = 0;

    logic [TW-1:0] mdl  [2][NB];
    logic [TW-1:0] snap [2][NB];

    typedef struct {
        logic       wr;
        logic       lane;
        logic [5:0] addr;
        logic [17:0] dat;
        logic       apply;
        logic [1:0] mask;
        logic       exp_busy;
        logic       exp_done;
        logic [1:0] exp_wr;
        logic [1:0] exp_upd;
    } vec_t;

    vec_t vecs [6];

    beam_thresh_sequencer dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .thr_wr_i        (thr_wr_i),
        .thr_lane_i      (thr_lane_i),
        .thr_addr_i      (thr_addr_i),
        .thr_dat_i       (thr_dat_i),
        .apply_i         (apply_i),
        .apply_mask_i    (apply_mask_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .thresh_o        (thresh_o),
        .thresh_wr_o     (thresh_wr_o),
        .thresh_update_o (thresh_update_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        thr_wr_i     = 1'b0;
        thr_lane_i   = 1'b0;
        thr_addr_i   = '0;
        thr_dat_i    = '0;
        apply_i      = 1'b0;
        apply_mask_i = 2'b00;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " busy"},   36'(busy_o),          36'(0));
        check({tag, " done"},   36'(done_o),          36'(0));
        check({tag, " wr"},     36'(thresh_wr_o),     36'(0));
        check({tag, " update"}, 36'(thresh_update_o), 36'(0));
    endtask

    task automatic host_write(input logic lane, input int addr, input logic [TW-1:0] dat);
        thr_wr_i   = 1'b1;
        thr_lane_i = lane;
        thr_addr_i = 6'(addr);
        thr_dat_i  = dat;
        if (addr < NB) mdl[lane][addr] = dat;
        tick();
        clear_inputs();
    endtask

    // Snapshots the model, then presents apply so that the next edge is cycle 0.
    task automatic start_apply(input logic [1:0] m);
        snap         = mdl;
        apply_i      = 1'b1;
        apply_mask_i = m;
        tick();
        clear_inputs();
    endtask

    // Called while observing cycle 1; returns while observing cycle 51 (DONE).
    // An optional event is presented so that it is sampled at edge ev_edge (0 = none).
    task automatic run_seq(input logic [1:0] m, input int ev_edge, input logic ev_is_apply,
                           input logic [1:0] ev_mask, input logic ev_lane, input int ev_addr,
                           input logic [TW-1:0] ev_dat);
        int beam;
        for (int c = 1; c <= 51; c++) begin
            check($sformatf("busy c%0d", c),   36'(busy_o),          36'(c <= 50));
            check($sformatf("done c%0d", c),   36'(done_o),          36'(c == 51));
            check($sformatf("wr c%0d", c),     36'(thresh_wr_o),     36'((c >= 2 && c <= 49) ? m : 2'b00));
            check($sformatf("update c%0d", c), 36'(thresh_update_o), 36'((c == 50) ? m : 2'b00));
            if (c >= 2) begin
                beam = (c <= 49) ? 49 - c : 0;
                if (m[0]) check($sformatf("lane0 data c%0d", c), 36'(thresh_o[17:0]),  36'(snap[0][beam]));
                if (m[1]) check($sformatf("lane1 data c%0d", c), 36'(thresh_o[35:18]), 36'(snap[1][beam]));
            end
            clear_inputs();
            if (c == ev_edge - 1) begin
                if (ev_is_apply) begin
                    apply_i      = 1'b1;
                    apply_mask_i = ev_mask;
                end else begin
                    thr_wr_i   = 1'b1;
                    thr_lane_i = ev_lane;
                    thr_addr_i = 6'(ev_addr);
                    thr_dat_i  = ev_dat;
                    if (ev_addr < NB) mdl[ev_lane][ev_addr] = ev_dat;
                end
            end
            if (c < 51) tick();
        end
    endtask

    task automatic end_seq(input string tag);
        clear_inputs();
        tick();
        check_quiet(tag);
    endtask

    initial begin
        for (int l = 0; l < 2; l++)
            for (int k = 0; k < NB; k++)
                mdl[l][k] = 18'd4000;

        vecs[0] = '{wr:0, lane:0, addr:0,  dat:0,   apply:0, mask:2'b00, exp_busy:0, exp_done:0, exp_wr:0, exp_upd:0};
        vecs[1] = '{wr:1, lane:0, addr:50, dat:3,   apply:0, mask:2'b00, exp_busy:0, exp_done:0, exp_wr:0, exp_upd:0};
        vecs[2] = '{wr:1, lane:1, addr:63, dat:5,   apply:0, mask:2'b00, exp_busy:0, exp_done:0, exp_wr:0, exp_upd:0};
        vecs[3] = '{wr:0, lane:0, addr:0,  dat:0,   apply:1, mask:2'b00, exp_busy:0, exp_done:0, exp_wr:0, exp_upd:0};
        vecs[4] = '{wr:1, lane:0, addr:48, dat:9,   apply:1, mask:2'b00, exp_busy:0, exp_done:0, exp_wr:0, exp_upd:0};
        vecs[5] = '{wr:0, lane:0, addr:0,  dat:0,   apply:0, mask:2'b00, exp_busy:0, exp_done:0, exp_wr:0, exp_upd:0};

        // Reset state
        tick();
        tick();
        check_quiet("reset");
        check("reset thresh", 36'(thresh_o), 36'(0));
        rst_i = 1'b0;
        tick();

        // Power-up RAM contents
        start_apply(2'b11);
        run_seq(2'b11, 0, 1'b0, 2'b00, 1'b0, 0, '0);
        end_seq("default idle");

        for (int l = 0; l < 2; l++)
            for (int k = 0; k < NB; k++)
                host_write(l[0], k, 18'(1000 * l + k));

        // Dropped writes and empty applies leave everything quiet
        for (int i = 0; i < 6; i++) begin
            thr_wr_i     = vecs[i].wr;
            thr_lane_i   = vecs[i].lane;
            thr_addr_i   = vecs[i].addr;
            thr_dat_i    = vecs[i].dat;
            apply_i      = vecs[i].apply;
            apply_mask_i = vecs[i].mask;
            tick();
            clear_inputs();
            check($sformatf("vec%0d busy", i),   36'(busy_o),          36'(vecs[i].exp_busy));
            check($sformatf("vec%0d done", i),   36'(done_o),          36'(vecs[i].exp_done));
            check($sformatf("vec%0d wr", i),     36'(thresh_wr_o),     36'(vecs[i].exp_wr));
            check($sformatf("vec%0d update", i), 36'(thresh_update_o), 36'(vecs[i].exp_upd));
        end

        // Full two-lane sequence
        start_apply(2'b11);
        run_seq(2'b11, 0, 1'b0, 2'b00, 1'b0, 0, '0);
        end_seq("mask11 idle");

        // Lane 0 only
        start_apply(2'b01);
        run_seq(2'b01, 0, 1'b0, 2'b00, 1'b0, 0, '0);
        end_seq("mask01 idle");

        // Apply while busy chains a second sequence straight from DONE
        start_apply(2'b01);
        run_seq(2'b01, 20, 1'b1, 2'b10, 1'b0, 0, '0);
        clear_inputs();
        tick();
        snap = mdl;
        run_seq(2'b10, 0, 1'b0, 2'b00, 1'b0, 0, '0);
        end_seq("chain idle");

        // Write to a beam not yet shifted is picked up in the same sequence
        start_apply(2'b01);
        snap[0][0] = 18'd777;
        run_seq(2'b01, 10, 1'b0, 2'b00, 1'b0, 0, 18'd777);
        end_seq("wr777 idle");

        // Write to a beam already shifted waits for the next apply
        start_apply(2'b01);
        run_seq(2'b01, 10, 1'b0, 2'b00, 1'b0, 47, 18'd555);
        end_seq("wr555 idle");
        start_apply(2'b01);
        check("555 model", 36'(snap[0][47]), 36'(555));
        run_seq(2'b01, 0, 1'b0, 2'b00, 1'b0, 0, '0);
        end_seq("after555 idle");

        // Reset in the middle of a sequence, with a pending request that must be lost
        start_apply(2'b11);
        for (int c = 1; c < 30; c++) begin
            clear_inputs();
            if (c == 24) begin
                apply_i      = 1'b1;
                apply_mask_i = 2'b10;
            end
            tick();
        end
        clear_inputs();
        check("pre-reset busy", 36'(busy_o),      36'(1));
        check("pre-reset wr",   36'(thresh_wr_o), 36'(2'b11));
        rst_i = 1'b1;
        #1;
        check_quiet("async reset");
        check("async reset thresh", 36'(thresh_o), 36'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check_quiet($sformatf("in reset %0d", i));
        end
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_quiet($sformatf("post reset %0d", i));
        end
        start_apply(2'b11);
        run_seq(2'b11, 0, 1'b0, 2'b00, 1'b0, 0, '0);
        end_seq("post-reset seq idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
